// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared ROB sizing, iType encodings and entry layout.
package reorder_buffer_pkg;
  localparam int ROB_SIZE = 8;
  localparam int ROB_IDX_W = $clog2(ROB_SIZE);
  localparam logic [3:0] IT_ADD = 4'd0, IT_ADDI = 4'd1, IT_LOAD = 4'd2, IT_STORE = 4'd3,
                         IT_BRANCH = 4'd4, IT_JAL = 4'd5, IT_JALR = 4'd6;
  typedef struct packed {
    logic        valid;
    logic        done;
    logic        mispredict;
    logic [4:0]  rd;
    logic [3:0]  itype;
    logic [31:0] data;
    logic [31:0] target;
  } rob_entry_t;
  function automatic logic writes_reg(input logic [3:0] itype, input logic [4:0] rd);
    return itype != IT_STORE && itype != IT_BRANCH && rd != 5'd0;
  endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: issue, CDB, query, commit and flush signals of the ROB.
interface reorder_buffer_if #(parameter int SIZE = 8, parameter int IDX_W = $clog2(SIZE));
  logic              alloc_valid_in;
  logic [4:0]        alloc_rd_in;
  logic [3:0]        alloc_itype_in;
  logic              alloc_ready_out;
  logic [IDX_W-1:0]  alloc_idx_out;
  logic              cdb_valid_in;
  logic [IDX_W-1:0]  cdb_rob_idx_in;
  logic [31:0]       cdb_data_in;
  logic              cdb_mispredict_in;
  logic [31:0]       cdb_target_in;
  logic [IDX_W-1:0]  q1_idx_in, q2_idx_in;
  logic              q1_ready_out, q2_ready_out;
  logic [31:0]       q1_data_out, q2_data_out;
  logic              commit_valid_out, commit_we_out;
  logic [4:0]        commit_rd_out;
  logic [31:0]       commit_data_out;
  logic [IDX_W-1:0]  commit_idx_out;
  logic              flush_out;
  logic [31:0]       flush_pc_out;
  logic [SIZE*5-1:0] flush_addrs_out;
  logic [IDX_W:0]    count_out;
  modport master (
    output alloc_valid_in, alloc_rd_in, alloc_itype_in, cdb_valid_in, cdb_rob_idx_in, cdb_data_in,
           cdb_mispredict_in, cdb_target_in, q1_idx_in, q2_idx_in,
    input  alloc_ready_out, alloc_idx_out, q1_ready_out, q2_ready_out, q1_data_out, q2_data_out,
           commit_valid_out, commit_we_out, commit_rd_out, commit_data_out, commit_idx_out,
           flush_out, flush_pc_out, flush_addrs_out, count_out
  );
  modport slave (
    input  alloc_valid_in, alloc_rd_in, alloc_itype_in, cdb_valid_in, cdb_rob_idx_in, cdb_data_in,
           cdb_mispredict_in, cdb_target_in, q1_idx_in, q2_idx_in,
    output alloc_ready_out, alloc_idx_out, q1_ready_out, q2_ready_out, q1_data_out, q2_data_out,
           commit_valid_out, commit_we_out, commit_rd_out, commit_data_out, commit_idx_out,
           flush_out, flush_pc_out, flush_addrs_out, count_out
  );
endinterface

// File: rtl/reorder_buffer_lookup.sv
// rob_lookup: one operand-tag query port; ROB_CDB_FWD_EN adds same-cycle CDB forwarding.
module rob_lookup #(parameter int IDX_W = 3) (
  input  logic [IDX_W-1:0] q_idx,
  input  logic             valid,
  input  logic             done,
  input  logic [31:0]      data,
  input  logic             cdb_valid,
  input  logic [IDX_W-1:0] cdb_idx,
  input  logic [31:0]      cdb_data,
  output logic             ready,
  output logic [31:0]      q_data
);
`ifdef ROB_CDB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic hit;
  assign hit = FWD && cdb_valid && cdb_idx == q_idx;
  assign ready = valid && (done || hit);
  assign q_data = !ready ? 32'd0 : hit ? cdb_data : data;
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB with CDB capture, in-order commit and mispredict flush.
// Optional ROB_CDB_FWD_EN: query ports forward same-cycle CDB results.
module reorder_buffer import reorder_buffer_pkg::*; #(
  parameter int SIZE = ROB_SIZE,
  parameter int IDX_W = $clog2(SIZE)
) (
  input logic clk_in,
  input logic rst_in,
  reorder_buffer_if.slave rob
);
  localparam logic [IDX_W:0] CAP = (IDX_W+1)'(SIZE);
  rob_entry_t ent [SIZE];
  rob_entry_t hd;
  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0] count;
  logic do_alloc, do_commit, do_flush;
  logic [SIZE*5-1:0] live_rds;
  assign hd = ent[head];
  assign rob.alloc_ready_out = rst_in && !rob.flush_out && count < CAP;
  assign rob.alloc_idx_out = tail;
  assign rob.count_out = count;
  assign do_alloc = rob.alloc_valid_in && rob.alloc_ready_out;
  assign do_commit = hd.valid && hd.done;
  assign do_flush = do_commit && hd.mispredict;
  for (genvar i = 0; i < SIZE; i++) begin : g_rd
    assign live_rds[5*i +: 5] = ent[i].valid ? ent[i].rd : 5'd0;
  end
  rob_lookup #(.IDX_W(IDX_W)) u_q1 (
    .q_idx(rob.q1_idx_in), .valid(ent[rob.q1_idx_in].valid), .done(ent[rob.q1_idx_in].done),
    .data(ent[rob.q1_idx_in].data), .cdb_valid(rob.cdb_valid_in), .cdb_idx(rob.cdb_rob_idx_in),
    .cdb_data(rob.cdb_data_in), .ready(rob.q1_ready_out), .q_data(rob.q1_data_out)
  );
  rob_lookup #(.IDX_W(IDX_W)) u_q2 (
    .q_idx(rob.q2_idx_in), .valid(ent[rob.q2_idx_in].valid), .done(ent[rob.q2_idx_in].done),
    .data(ent[rob.q2_idx_in].data), .cdb_valid(rob.cdb_valid_in), .cdb_idx(rob.cdb_rob_idx_in),
    .cdb_data(rob.cdb_data_in), .ready(rob.q2_ready_out), .q_data(rob.q2_data_out)
  );
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < SIZE; i++) ent[i] <= '0;
      rob.commit_valid_out <= 1'b0;
      rob.commit_we_out <= 1'b0;
      rob.commit_rd_out <= '0;
      rob.commit_data_out <= '0;
      rob.commit_idx_out <= '0;
      rob.flush_out <= 1'b0;
      rob.flush_pc_out <= '0;
      rob.flush_addrs_out <= '0;
    end else begin
      rob.commit_valid_out <= do_commit;
      rob.commit_we_out <= do_commit && !hd.mispredict && writes_reg(hd.itype, hd.rd);
      rob.flush_out <= do_flush;
      if (do_commit) begin
        rob.commit_rd_out <= hd.rd;
        rob.commit_data_out <= hd.data;
        rob.commit_idx_out <= head;
      end
      if (do_flush) begin
        rob.flush_pc_out <= hd.target;
        rob.flush_addrs_out <= live_rds;
        head <= '0;
        tail <= '0;
        count <= '0;
        for (int i = 0; i < SIZE; i++) ent[i] <= '0;
      end else begin
        if (rob.cdb_valid_in && ent[rob.cdb_rob_idx_in].valid) begin
          ent[rob.cdb_rob_idx_in].done <= 1'b1;
          ent[rob.cdb_rob_idx_in].data <= rob.cdb_data_in;
          ent[rob.cdb_rob_idx_in].mispredict <= rob.cdb_mispredict_in;
          ent[rob.cdb_rob_idx_in].target <= rob.cdb_target_in;
        end
        // the tail slot is never the committing head unless full, when alloc is blocked
        if (do_alloc)
          ent[tail] <= '{valid: 1'b1, done: 1'b0, mispredict: 1'b0, rd: rob.alloc_rd_in,
                         itype: rob.alloc_itype_in, data: '0, target: '0};
        if (do_commit) begin
          ent[head].valid <= 1'b0;
          head <= head + IDX_W'(1);
        end
        tail <= tail + IDX_W'(do_alloc);
        count <= count + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_commit);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed plan plus random traffic against a program-order queue model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;
`ifdef ROB_CDB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct {
    logic [2:0]  idx;
    logic [4:0]  rd;
    logic [3:0]  it;
    bit          done;
    logic [31:0] data;
    bit          mp;
    logic [31:0] tgt;
  } ment_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0;
  ment_t q[$];
  logic [2:0] nidx;
  logic exp_cv, exp_we, exp_fl;
  logic [4:0] exp_rd;
  logic [31:0] exp_data, exp_pc;
  logic [2:0] exp_idx;
  logic [39:0] exp_addrs;
  reorder_buffer_if rif ();
  reorder_buffer dut (.clk_in(clk), .rst_in(rst_n), .rob(rif));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    rif.alloc_valid_in = 0; rif.alloc_rd_in = 0; rif.alloc_itype_in = 0;
    rif.cdb_valid_in = 0; rif.cdb_rob_idx_in = 0; rif.cdb_data_in = 0;
    rif.cdb_mispredict_in = 0; rif.cdb_target_in = 0;
    rif.q1_idx_in = 0; rif.q2_idx_in = 0;
  endtask
  task automatic model_reset();
    q.delete(); nidx = 0;
    exp_cv = 0; exp_we = 0; exp_fl = 0; exp_rd = 0; exp_data = 0; exp_pc = 0; exp_idx = 0; exp_addrs = 0;
  endtask
  task automatic mq(input logic [2:0] ix, output logic r, output logic [31:0] d);
    bit hit;
    hit = FWD && rif.cdb_valid_in && rif.cdb_rob_idx_in == ix;
    r = 0; d = 0;
    foreach (q[k]) if (q[k].idx == ix && (q[k].done || hit)) begin
      r = 1; d = hit ? rif.cdb_data_in : q[k].data;
    end
  endtask
  function automatic bit m_ready();
    return !exp_fl && q.size() < 8;
  endfunction
  task automatic check_all();
    logic r; logic [31:0] d;
    chk("alloc_ready", rif.alloc_ready_out, m_ready());
    chk("alloc_idx", rif.alloc_idx_out, nidx);
    chk("count", rif.count_out, q.size());
    mq(rif.q1_idx_in, r, d);
    chk("q1_ready", rif.q1_ready_out, r);
    chk("q1_data", rif.q1_data_out, d);
    mq(rif.q2_idx_in, r, d);
    chk("q2_ready", rif.q2_ready_out, r);
    chk("q2_data", rif.q2_data_out, d);
    chk("commit_valid", rif.commit_valid_out, exp_cv);
    chk("commit_we", rif.commit_we_out, exp_we);
    chk("commit_rd", rif.commit_rd_out, exp_rd);
    chk("commit_data", rif.commit_data_out, exp_data);
    chk("commit_idx", rif.commit_idx_out, exp_idx);
    chk("flush", rif.flush_out, exp_fl);
    chk("flush_pc", rif.flush_pc_out, exp_pc);
    chk("flush_addrs", rif.flush_addrs_out, exp_addrs);
  endtask
  task automatic model_step();
    bit rdy, com, fl;
    rdy = m_ready();
    com = q.size() > 0 && q[0].done;
    fl = com && q[0].mp;
    exp_cv = com; exp_we = 0; exp_fl = fl;
    if (com) begin
      exp_rd = q[0].rd; exp_data = q[0].data; exp_idx = q[0].idx;
      exp_we = !q[0].mp && q[0].it != IT_STORE && q[0].it != IT_BRANCH && q[0].rd != 0;
    end
    if (fl) begin
      exp_pc = q[0].tgt; exp_addrs = 0;
      foreach (q[k]) exp_addrs[5*int'(q[k].idx) +: 5] = q[k].rd;
      q.delete(); nidx = 0;
    end else begin
      if (rif.cdb_valid_in) foreach (q[k]) if (q[k].idx == rif.cdb_rob_idx_in) begin
        q[k].done = 1; q[k].data = rif.cdb_data_in; q[k].mp = rif.cdb_mispredict_in; q[k].tgt = rif.cdb_target_in;
      end
      if (com) void'(q.pop_front());
      if (rif.alloc_valid_in && rdy) begin
        q.push_back('{idx: nidx, rd: rif.alloc_rd_in, it: rif.alloc_itype_in, done: 0, data: 0, mp: 0, tgt: 0});
        nidx = nidx + 3'd1;
      end
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    idle();
    #1;
    chk("rst_count", rif.count_out, 0);
    chk("rst_ready", rif.alloc_ready_out, 0);
    chk("rst_commit_valid", rif.commit_valid_out, 0);
    chk("rst_flush", rif.flush_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask
  task automatic alloc(input logic [4:0] rd, input logic [3:0] it);
    rif.alloc_valid_in = 1; rif.alloc_rd_in = rd; rif.alloc_itype_in = it;
    cyc();
    rif.alloc_valid_in = 0;
  endtask
  task automatic cdb(input logic [2:0] ix, input logic [31:0] d, input bit mp, input logic [31:0] tgt);
    rif.cdb_valid_in = 1; rif.cdb_rob_idx_in = ix; rif.cdb_data_in = d;
    rif.cdb_mispredict_in = mp; rif.cdb_target_in = tgt;
    cyc();
    rif.cdb_valid_in = 0; rif.cdb_mispredict_in = 0;
  endtask
  initial begin
    idle();
    model_reset();
    do_reset();
    cyc();
    // in-order commit of out-of-order results
    alloc(5, IT_ADD); alloc(6, IT_ADD); alloc(7, IT_ADD);
    chk("plan_count3", rif.count_out, 3);
    cdb(1, 32'h22, 0, 0);
    cdb(0, 32'h11, 0, 0);
    cyc();
    chk("plan_c0_rd", rif.commit_rd_out, 5);
    chk("plan_c0_data", rif.commit_data_out, 32'h11);
    cyc();
    chk("plan_c1_rd", rif.commit_rd_out, 6);
    chk("plan_c1_data", rif.commit_data_out, 32'h22);
    cyc();
    chk("plan_idx2_stays", rif.commit_valid_out, 0);
    // full, ignored 9th alloc, commit-while-full, wrap
    do_reset();
    for (int i = 0; i < 8; i++) alloc(5'(i + 1), IT_ADD);
    chk("plan_full_ready", rif.alloc_ready_out, 0);
    alloc(20, IT_ADD);
    chk("plan_full_count", rif.count_out, 8);
    rif.alloc_valid_in = 1; rif.alloc_rd_in = 9; rif.alloc_itype_in = IT_ADD;
    cdb(0, 32'h99, 0, 0);
    rif.alloc_valid_in = 1;
    cyc();
    chk("plan_wrap_idx", rif.alloc_idx_out, 0);
    cyc();
    rif.alloc_valid_in = 0;
    chk("plan_wrap_count", rif.count_out, 8);
    // non-writing commits
    do_reset();
    alloc(0, IT_STORE);
    cdb(0, 32'h5, 0, 0);
    cyc();
    chk("plan_store_cv", rif.commit_valid_out, 1);
    chk("plan_store_we", rif.commit_we_out, 0);
    alloc(0, IT_ADDI);
    cdb(1, 32'h6, 0, 0);
    cyc();
    chk("plan_addi_r0_we", rif.commit_we_out, 0);
    // mispredict flush
    do_reset();
    alloc(0, IT_BRANCH); alloc(3, IT_ADD); alloc(4, IT_ADD);
    cdb(0, 32'h0, 1, 32'h40);
    cyc();
    chk("plan_flush", rif.flush_out, 1);
    chk("plan_flush_pc", rif.flush_pc_out, 32'h40);
    chk("plan_flush_addrs", rif.flush_addrs_out, 40'h1060);
    chk("plan_flush_count", rif.count_out, 0);
    chk("plan_flush_ready", rif.alloc_ready_out, 0);
    cyc();
    // queries, with and without forwarding
    do_reset();
    alloc(1, IT_ADD); alloc(2, IT_ADD); alloc(3, IT_ADD);
    rif.q1_idx_in = 2;
    #1;
    chk("plan_q_notdone", rif.q1_ready_out, 0);
    rif.cdb_valid_in = 1; rif.cdb_rob_idx_in = 2; rif.cdb_data_in = 32'hDEAD;
    #1;
    chk("plan_q_fwd", rif.q1_ready_out, FWD);
    cyc();
    rif.cdb_valid_in = 0;
    #1;
    chk("plan_q_ready", rif.q1_ready_out, 1);
    chk("plan_q_data", rif.q1_data_out, 32'hDEAD);
    cyc();
    // asynchronous reset with live entries
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 8), IT_ADD);
    chk("plan_live4", rif.count_out, 4);
    do_reset();
    cyc();
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rif.alloc_valid_in = $urandom_range(0, 9) < 6;
      rif.alloc_rd_in = 5'($urandom);
      rif.alloc_itype_in = 4'($urandom_range(0, 6));
      rif.cdb_valid_in = $urandom_range(0, 1);
      rif.cdb_rob_idx_in = 3'($urandom);
      rif.cdb_data_in = $urandom;
      rif.cdb_mispredict_in = $urandom_range(0, 24) == 0;
      rif.cdb_target_in = $urandom;
      rif.q1_idx_in = 3'($urandom);
      rif.q2_idx_in = 3'($urandom);
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
